// File: rtl/bcd_to_bin_seq_pkg.sv
// Shared constants, FSM state type and BCD validity helper for the BCD-to-binary converter.
package bcd_to_bin_seq_pkg;

  localparam int DIGITS = 4;
  localparam int BCD_W  = 4 * DIGITS;
  localparam int BIN_W  = 14;
  localparam int CNT_W  = $clog2(BIN_W + 1);
  localparam int R_W    = BCD_W + BIN_W;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic bcd_invalid(input logic [BCD_W-1:0] bcd);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/bcd_to_bin_seq_if.sv
// Start/ready/done handshake and data bundle between a requester and the BCD-to-binary converter.
interface bcd_to_bin_seq_if;
  import bcd_to_bin_seq_pkg::*;

  logic             start;
  logic [BCD_W-1:0] bcd_in;
  logic             ready;
  logic             busy;
  logic             done;
  logic [BIN_W-1:0] bin_out;
  logic             err;

  modport master (
    output start, bcd_in,
    input  ready, busy, done, bin_out, err
  );

  modport slave (
    input  start, bcd_in,
    output ready, busy, done, bin_out, err
  );

endinterface

// File: rtl/bcd_to_bin_seq_nibble_adj.sv
// Reverse double-dabble digit correction: a shifted nibble >= 8 is pulled back by 3.
// Purely combinational, zero latency, no flow control.
module bcd_to_bin_seq_nibble_adj (
  input  logic [3:0] in_i,
  output logic [3:0] out_o
);

  assign out_o = (in_i >= 4'd8) ? (in_i - 4'd3) : in_i;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter, one reverse double-dabble iteration per clock.
// Latency BIN_W cycles from accept to done; start is only taken while ready, otherwise ignored.
module bcd_to_bin_seq
  import bcd_to_bin_seq_pkg::*;
(
  input logic           clk,
  input logic           rst_n,
  bcd_to_bin_seq_if.slave bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [R_W-1:0]   sh_q, sh_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic             err_q, err_d;
  logic             bad_q, bad_d;

  logic [R_W-1:0]   sh_right;
  logic [BCD_W-1:0] bcd_adj;
  logic [R_W-1:0]   sh_step;

  assign sh_right = sh_q >> 1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_to_bin_seq_nibble_adj u_adj (
      .in_i  (sh_right[BIN_W + 4*g +: 4]),
      .out_o (bcd_adj[4*g +: 4])
    );
  end

  assign sh_step = {bcd_adj, sh_right[BIN_W-1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    bin_d   = bin_q;
    err_d   = err_q;
    bad_d   = bad_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          sh_d    = {bus.bcd_in, {BIN_W{1'b0}}};
          cnt_d   = '0;
          bad_d   = bcd_invalid(bus.bcd_in);
          state_d = ST_SHIFT;
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        sh_d  = sh_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = ST_DONE;
          bin_d   = bad_q ? '0 : sh_step[BIN_W-1:0];
          err_d   = bad_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      bin_q   <= '0;
      err_q   <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
      bad_q   <= bad_d;
    end
  end

  // done is exactly the single DONE-state cycle, so it cannot stretch or repeat
  assign bus.ready   = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign bus.busy    = (state_q == ST_SHIFT);
  assign bus.done    = (state_q == ST_DONE);
  assign bus.bin_out = bin_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed bench for bcd_to_bin_seq: latency, handshake, error flag, abort and a strided value sweep.
module tb_bcd_to_bin_seq;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   done_cnt = 0;
  int   prev_exp = 0;

  bcd_to_bin_seq_if bif();

  bcd_to_bin_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (bif.done) done_cnt <= done_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic accept(input logic [15:0] bcd);
    int w;
    w = 0;
    while (!bif.ready && w < 50) begin
      tick();
      w++;
    end
    bif.start  = 1'b1;
    bif.bcd_in = bcd;
    tick();
    acc_cyc    = cyc;
    bif.start  = 1'b0;
    bif.bcd_in = ~bcd;
  endtask

  task automatic wait_done(output int lat);
    while (!bif.done && (cyc - acc_cyc) < 40) begin
      tick();
      if (cyc - acc_cyc == 5) check("bin_held_mid", 32'(bif.bin_out), 32'(prev_exp));
    end
    lat = cyc - acc_cyc;
  endtask

  task automatic run_conv(input string tag, input logic [15:0] bcd, input int exp_bin, input logic exp_err);
    int lat;
    accept(bcd);
    check({tag, "_busy"}, 32'(bif.busy), 32'd1);
    wait_done(lat);
    check({tag, "_latency"}, 32'(lat), 32'd14);
    check({tag, "_bin"}, 32'(bif.bin_out), 32'(exp_bin));
    check({tag, "_err"}, 32'(bif.err), 32'(exp_err));
    check({tag, "_ready"}, 32'(bif.ready), 32'd1);
    if (!exp_err) check({tag, "_residue"}, 32'(dut.sh_q >> 14), 32'd0);
    prev_exp = exp_bin;
  endtask

  initial begin
    int lat;
    int dc0;
    rst_n      = 1'b0;
    bif.start  = 1'b1;
    bif.bcd_in = 16'h1234;
    tick();
    tick();
    check("rst_ready", 32'(bif.ready), 32'd1);
    check("rst_busy", 32'(bif.busy), 32'd0);
    check("rst_done", 32'(bif.done), 32'd0);
    check("rst_bin", 32'(bif.bin_out), 32'd0);
    check("rst_err", 32'(bif.err), 32'd0);
    bif.start = 1'b0;
    rst_n     = 1'b1;
    tick();
    check("idle_busy", 32'(bif.busy), 32'd0);

    run_conv("zero", 16'h0000, 0, 1'b0);
    tick();
    check("done_single", 32'(bif.done), 32'd0);
    run_conv("d9999", 16'h9999, 9999, 1'b0);
    run_conv("d1234", 16'h1234, 1234, 1'b0);

    run_conv("bad12A4", 16'h12A4, 0, 1'b1);
    run_conv("d0042", 16'h0042, 42, 1'b0);

    // start pulsed mid-conversion must not disturb the running one
    tick();
    dc0 = done_cnt;
    accept(16'h0500);
    tick();
    tick();
    tick();
    bif.start  = 1'b1;
    bif.bcd_in = 16'h0777;
    tick();
    bif.start  = 1'b0;
    check("ign_busy", 32'(bif.busy), 32'd1);
    wait_done(lat);
    check("ign_latency", 32'(lat), 32'd14);
    check("ign_bin", 32'(bif.bin_out), 32'd500);
    check("ign_err", 32'(bif.err), 32'd0);
    tick();
    tick();
    tick();
    check("ign_done_count", 32'(done_cnt - dc0), 32'd1);
    check("ign_ready", 32'(bif.ready), 32'd1);
    check("ign_bin_hold", 32'(bif.bin_out), 32'd500);
    prev_exp = 500;

    accept(16'h0321);
    for (int i = 0; i < 6; i++) tick();
    check("abort_busy_pre", 32'(bif.busy), 32'd1);
    dc0   = done_cnt;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_ready", 32'(bif.ready), 32'd1);
    check("abort_busy", 32'(bif.busy), 32'd0);
    check("abort_bin", 32'(bif.bin_out), 32'd0);
    check("abort_err", 32'(bif.err), 32'd0);
    for (int i = 0; i < 20; i++) tick();
    check("abort_no_done", 32'(done_cnt - dc0), 32'd0);
    prev_exp = 0;
    run_conv("d0010", 16'h0010, 10, 1'b0);

    // back-to-back: each call asserts start in the done cycle of the previous one
    dc0 = cyc;
    for (int v = 1; v <= 99; v++) run_conv("b2b", to_bcd(v), v, 1'b0);
    check("b2b_period", 32'(cyc - dc0), 32'(99 * 15));

    for (int v = 0; v <= 9999; v += 13) run_conv("sweep", to_bcd(v), v, 1'b0);
    run_conv("sweep_max", 16'h9999, 9999, 1'b0);
    run_conv("bad_F000", 16'hF000, 0, 1'b1);
    run_conv("d0007", 16'h0007, 7, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
